// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between the execute (EX) and address-generation (AG) ports,
// owns the CCR {C,V,N,Z} and a small LIFO of saved CCR values for interrupt entry/return.
module alu_arbiter #(
  parameter int FSTK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_req,
  input  logic [7:0] ex_a,
  input  logic [7:0] ex_b,
  input  logic [3:0] ex_op,
  output logic       ex_gnt,
  output logic       ex_done,
  input  logic       ag_req,
  input  logic [7:0] ag_a,
  input  logic [7:0] ag_b,
  input  logic [3:0] ag_op,
  output logic       ag_gnt,
  output logic       ag_done,
  output logic [7:0] result,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [3:0] ccr,
  input  logic       flag_save,
  input  logic       flag_restore,
  output logic [2:0] fstk_cnt,
  output logic       fstk_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;            // 1 = EX, 0 = AG
  logic       last_owner_q, last_owner_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [3:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic [3:0] ccr_q, ccr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [3:0] fstk_q [4];
  logic [3:0] fstk_d [4];

  logic       arb_en, ex_win, ex_gnt_c, ag_gnt_c;
  logic       full, empty, push, pop, stk_err;
  logic [1:0] top_idx;

  // Arbitration is open only while no operation occupies the ALU.
  always_comb begin
    arb_en   = (state_q == IDLE) || (state_q == DONE);
    ex_win   = ex_req && (!ag_req || !last_owner_q);
    ex_gnt_c = arb_en && ex_win;
    ag_gnt_c = arb_en && ag_req && !ex_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      op_q         <= 4'h0;
      result_q     <= 8'h00;
      ccr_q        <= 4'h0;
      cnt_q        <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      ccr_q        <= ccr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    fstk_q <= fstk_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ex_gnt_c || ag_gnt_c) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = (ex_gnt_c || ag_gnt_c) ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    ccr_d        = ccr_q;
    if (ex_gnt_c) begin
      owner_d      = 1'b1;
      last_owner_d = 1'b1;
      a_d          = ex_a;
      b_d          = ex_b;
      op_d         = ex_op;
    end else if (ag_gnt_c) begin
      owner_d      = 1'b0;
      last_owner_d = 1'b0;
      a_d          = ag_a;
      b_d          = ag_b;
      op_d         = ag_op;
    end else if (state_d == IDLE) begin
      a_d  = 8'h00;
      b_d  = 8'h00;
      op_d = 4'h0;
    end
    if (state_q == EXEC) begin
      result_d = alu_out;
      if (owner_q) ccr_d = alu_flags;
    end

    // Flag stack: a restore wins over a same-cycle EX flag commit.
    full    = (cnt_q == 3'(FSTK_DEPTH));
    empty   = (cnt_q == 3'd0);
    stk_err = (flag_save && flag_restore) || (flag_save && full) ||
              (flag_restore && empty);
    push    = flag_save && !flag_restore && !full;
    pop     = flag_restore && !flag_save && !empty;
    top_idx = 2'(cnt_q - 3'd1);
    fstk_d  = fstk_q;
    cnt_d   = cnt_q;
    err_d   = stk_err;
    if (push) begin
      fstk_d[cnt_q[1:0]] = ccr_q;
      cnt_d              = cnt_q + 3'd1;
    end
    if (pop) begin
      ccr_d = fstk_q[top_idx];
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_comb begin
    ex_gnt     = ex_gnt_c;
    ag_gnt     = ag_gnt_c;
    ex_done    = (state_q == DONE) && owner_q;
    ag_done    = (state_q == DONE) && !owner_q;
    result     = result_q;
    alu_a      = a_q;
    alu_b      = b_q;
    alu_opcode = op_q;
    ccr        = ccr_q;
    fstk_cnt   = cnt_q;
    fstk_err   = err_q;
  end

endmodule
